core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
Multi-cycle control FSM for the RV32I core. It steps each instruction through FETCH, DECODE, EXECUTE, MEM and WB, and owns the PC. It drives the instruction register feeding i_decoder and consumes i_decoder's control outputs (mem_read, mem_write, mem_to_reg, reg_write_out, branch, jump). It issues the req/ack handshakes to instruction and data memory, gates register-file writes, and traps on memory timeouts or illegal control combinations.

Parameters:
WORD_SIZE, 32, instruction/data word width
ADDR_SIZE, 10, PC/byte-address width
MEM_TIMEOUT, 16, maximum wait cycles for imem/dmem ack; 0 disables the timeout
TO_W, $clog2(MEM_TIMEOUT+1), timeout counter width

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_SIZE  fetch address (= pc)
imem_ack  in  1  fetch data valid
imem_rdata  in  WORD_SIZE  fetched instruction
instr  out  WORD_SIZE  registered instruction to i_decoder
dec_mem_read  in  1  i_decoder mem_read
dec_mem_write  in  1  i_decoder mem_write
dec_mem_to_reg  in  1  i_decoder mem_to_reg
dec_reg_write  in  1  i_decoder reg_write_out
dec_branch  in  1  i_decoder branch
dec_jump  in  1  i_decoder jump
branch_taken  in  1  ALU comparison result, valid in EXECUTE
target_addr  in  ADDR_SIZE  branch/jump target, valid in EXECUTE
dmem_req  out  1  data memory request
dmem_we  out  1  1 = store, 0 = load
dmem_ack  in  1  data access complete
reg_we  out  1  register file write enable
wb_sel  out  1  1 = memory data, 0 = ALU result
pc  out  ADDR_SIZE  current PC
retire  out  1  one-cycle pulse when an instruction completes
fault  out  1  sticky trap flag
state  out  3  FSM state for debug

Behaviour:
- Reset values on the rst_n=0 edge:
  - state=FETCH, pc=0, instr=32'h00000013 (NOP), next_pc=0, timeout counter=0, fault=0.
  - All combinational outputs take their FETCH values.
- State encoding: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, FAULT=5. Codes 6-7 go to FAULT.
- imem_req = (state==FETCH); imem_addr = pc.
- dmem_req = (state==MEM); dmem_we = dec_mem_write in MEM, else 0.
- reg_we = (state==WB); wb_sel = dec_mem_to_reg.
- FETCH: hold imem_req until imem_ack is sampled 1. On ack: instr<=imem_rdata, go DECODE. An ack on the same cycle as req entry is legal (0-wait).
- DECODE: one cycle; i_decoder settles on instr. Go EXECUTE.
- EXECUTE: one cycle.
  - next_pc <= (dec_jump | (dec_branch & branch_taken)) ? target_addr : pc+4. The add wraps modulo 2^ADDR_SIZE.
  - Next state is chosen in this priority order:
    1. dec_mem_read & dec_mem_write -> FAULT.
    2. Selected target with target_addr[1:0]!=0 -> FAULT.
    3. dec_mem_read | dec_mem_write -> MEM.
    4. dec_reg_write -> WB.
    5. Otherwise -> FETCH with pc<=next_pc and retire=1.
- MEM: hold dmem_req until dmem_ack. On ack: if dec_mem_read & dec_mem_write... no: if dec_mem_read & dec_reg_write -> WB; otherwise -> FETCH with pc<=next_pc and retire=1.
- WB: reg_we=1 for exactly one cycle, then FETCH with pc<=next_pc and retire=1.
- retire asserts on the cycle the FSM leaves the instruction's last state. pc updates on that same edge.
- Timeout:
  - The counter clears on entry to FETCH/MEM and increments each cycle in FETCH/MEM without ack.
  - If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with ack still 0, go FAULT on that edge.
  - An ack on the same cycle the counter reaches MEM_TIMEOUT wins: no fault.
- FAULT: fault=1, all requests and reg_we=0, pc frozen. Only reset exits.
- Acks received outside FETCH/MEM are ignored.
- instr holds its value after FETCH. i_decoder controls stay stable through MEM/WB.
- Reset mid-operation, including while a req is outstanding: the req drops at the next edge, and a late ack arriving after reset is ignored unless the FSM is in FETCH.

Test Plan:
- ADD 32'h00ee8c33, imem_ack at cycle 0 -> states 0,1,2,4,0; reg_we=1 in WB with wb_sel=0; retire on the WB cycle; pc 0->4. Total 4 cycles/instr.
- LW with dmem_ack after 3 wait cycles -> dmem_req high for 4 cycles with dmem_we=0; then WB with wb_sel=1, reg_we for 1 cycle; pc=4.
- SW -> MEM with dmem_we=1, no WB, reg_we never high; retire on the ack cycle; pc=4.
- BEQ at pc=8 with branch_taken=1, target 0x40 -> pc=0x40 after EXECUTE, no MEM/WB. Same with branch_taken=0 -> pc=0xC. JAL to target 0x3FE (misaligned) -> FAULT, fault=1, pc stays 8.
- Timeout: imem_ack held 0 with MEM_TIMEOUT=16 -> FAULT after 16 FETCH cycles. Ack on exactly the 16th count -> no fault, DECODE entered.
- pc=0x3FC sequential instruction -> pc wraps to 0. rst_n=0 during MEM wait -> dmem_req=0 next cycle, state=0, pc=0, fault=0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32I core.
// Owns the PC and instruction register, runs the imem/dmem handshakes and traps on faults.
//
// state   | meaning
// FETCH   | imem_req held until imem_ack; instruction latched on ack
// DECODE  | one cycle for i_decoder to settle on instr
// EXECUTE | next PC chosen, legality checked, route to MEM/WB/FETCH
// MEM     | dmem_req held until dmem_ack
// WB      | one-cycle register file write
// FAULT   | sticky trap; only reset leaves
module core_sequencer #(
    parameter int WORD_SIZE   = 32,
    parameter int ADDR_SIZE   = 10,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    output logic [WORD_SIZE-1:0] instr,
    input  logic                 dec_mem_read,
    input  logic                 dec_mem_write,
    input  logic                 dec_mem_to_reg,
    input  logic                 dec_reg_write,
    input  logic                 dec_branch,
    input  logic                 dec_jump,
    input  logic                 branch_taken,
    input  logic [ADDR_SIZE-1:0] target_addr,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ack,
    output logic                 reg_we,
    output logic                 wb_sel,
    output logic [ADDR_SIZE-1:0] pc,
    output logic                 retire,
    output logic                 fault,
    output logic [2:0]           state
);

    // A disabled timeout gives TO_W of 0; keep at least one counter bit.
    localparam int CNT_W = (TO_W < 1) ? 1 : TO_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [WORD_SIZE-1:0] NOP = WORD_SIZE'(32'h0000_0013);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [ADDR_SIZE-1:0] pc_q, pc_d;
    logic [ADDR_SIZE-1:0] next_pc_q, next_pc_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fault_q, fault_d;
    logic                 take_target;
    logic                 timed_out;
    logic                 retire_c;
    logic [ADDR_SIZE-1:0] seq_pc;
    logic [ADDR_SIZE-1:0] sel_pc;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        next_pc_d   = next_pc_q;
        instr_d     = instr_q;
        cnt_d       = '0;
        fault_d     = fault_q;
        retire_c    = 1'b0;
        take_target = dec_jump | (dec_branch & branch_taken);
        seq_pc      = pc_q + ADDR_SIZE'(4);
        sel_pc      = take_target ? target_addr : seq_pc;
        // The count reaching MEM_TIMEOUT on this edge is a fault only if no ack arrived.
        timed_out   = (MEM_TIMEOUT != 0) && (cnt_q == CNT_LAST);

        case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                next_pc_d = sel_pc;
                if (dec_mem_read & dec_mem_write) begin
                    state_d = S_FAULT;
                end else if (take_target && (target_addr[1:0] != 2'b00)) begin
                    state_d = S_FAULT;
                end else if (dec_mem_read | dec_mem_write) begin
                    state_d = S_MEM;
                end else if (dec_reg_write) begin
                    state_d = S_WB;
                end else begin
                    state_d  = S_FETCH;
                    pc_d     = sel_pc;
                    retire_c = 1'b1;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (dec_mem_read & dec_reg_write) begin
                        state_d = S_WB;
                    end else begin
                        state_d  = S_FETCH;
                        pc_d     = next_pc_q;
                        retire_c = 1'b1;
                    end
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                state_d  = S_FETCH;
                pc_d     = next_pc_q;
                retire_c = 1'b1;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        if (state_d == S_FAULT) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            next_pc_q <= '0;
            instr_q   <= NOP;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            next_pc_q <= next_pc_d;
            instr_q   <= instr_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign dmem_req  = (state_q == S_MEM);
    assign dmem_we   = (state_q == S_MEM) & dec_mem_write;
    assign reg_we    = (state_q == S_WB);
    assign wb_sel    = dec_mem_to_reg;
    assign pc        = pc_q;
    assign retire    = retire_c;
    assign fault     = fault_q;
    assign state     = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-instruction state traces predicted from
// the sequencing rules, with randomized wait states, targets and ack noise.
module tb_core_sequencer;

    localparam int AW = 10;
    localparam int WW = 32;
    localparam int MT = 16;

    logic          clk;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [WW-1:0] imem_rdata;
    logic [WW-1:0] instr;
    logic          dec_mem_read, dec_mem_write, dec_mem_to_reg;
    logic          dec_reg_write, dec_branch, dec_jump;
    logic          branch_taken;
    logic [AW-1:0] target_addr;
    logic          dmem_req, dmem_we, dmem_ack;
    logic          reg_we, wb_sel;
    logic [AW-1:0] pc;
    logic          retire, fault;
    logic [2:0]    state;

    int            checks;
    int            errors;
    logic [AW-1:0] model_pc;

    core_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_mem_to_reg(dec_mem_to_reg),
        .dec_reg_write (dec_reg_write),
        .dec_branch    (dec_branch),
        .dec_jump      (dec_jump),
        .branch_taken  (branch_taken),
        .target_addr   (target_addr),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_ack      (dmem_ack),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .pc            (pc),
        .retire        (retire),
        .fault         (fault),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        model_pc = '0;
    endtask

    // Runs one instruction. Expected per-cycle states come from the sequencing rules:
    // FETCH for (iw+1) cycles, DECODE, EXECUTE, optional MEM for (dw+1) cycles, optional WB.
    task automatic run_instr(input bit mr, input bit mw, input bit mtr, input bit rw,
                             input bit br, input bit jp, input bit bt,
                             input logic [AW-1:0] tgt, input int iw, input int dw,
                             input string name, output bit faulted);
        int            exp_st[$];
        bit            ia[$];
        bit            da[$];
        bit            sel, bad;
        logic [AW-1:0] npc;
        logic [WW-1:0] word;
        int            e_st, last;

        sel  = jp | (br & bt);
        npc  = sel ? tgt : model_pc + AW'(4);
        bad  = 1'b0;
        word = $urandom;

        if (iw >= MT) begin
            for (int i = 0; i < MT; i++) begin exp_st.push_back(0); ia.push_back(0); da.push_back(0); end
            bad = 1'b1;
        end else begin
            for (int i = 0; i < iw; i++) begin exp_st.push_back(0); ia.push_back(0); da.push_back(0); end
            exp_st.push_back(0); ia.push_back(1); da.push_back(0);
        end
        if (!bad) begin
            exp_st.push_back(1); ia.push_back(0); da.push_back(0);
            exp_st.push_back(2); ia.push_back(0); da.push_back(0);
            if ((mr && mw) || (sel && tgt[1:0] != 2'b00)) begin
                bad = 1'b1;
            end else if (mr || mw) begin
                if (dw >= MT) begin
                    for (int i = 0; i < MT; i++) begin exp_st.push_back(3); ia.push_back(0); da.push_back(0); end
                    bad = 1'b1;
                end else begin
                    for (int i = 0; i < dw; i++) begin exp_st.push_back(3); ia.push_back(0); da.push_back(0); end
                    exp_st.push_back(3); ia.push_back(0); da.push_back(1);
                    if (mr && rw) begin exp_st.push_back(4); ia.push_back(0); da.push_back(0); end
                end
            end else if (rw) begin
                exp_st.push_back(4); ia.push_back(0); da.push_back(0);
            end
        end
        if (bad) begin
            for (int i = 0; i < 3; i++) begin exp_st.push_back(5); ia.push_back(0); da.push_back(0); end
        end
        last = exp_st.size() - 1;

        dec_mem_read   = mr;
        dec_mem_write  = mw;
        dec_mem_to_reg = mtr;
        dec_reg_write  = rw;
        dec_branch     = br;
        dec_jump       = jp;
        branch_taken   = bt;
        target_addr    = tgt;

        for (int k = 0; k <= last; k++) begin
            e_st       = exp_st[k];
            imem_ack   = ia[k] | ((e_st != 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            dmem_ack   = da[k] | ((e_st != 3) ? 1'($urandom_range(0, 1)) : 1'b0);
            imem_rdata = ia[k] ? word : $urandom;
            #1;
            checks++; if (state !== e_st[2:0]) begin errors++; $display("FAIL %s cyc%0d state got %0d exp %0d", name, k, state, e_st); end
            checks++; if (imem_req !== (e_st == 0)) begin errors++; $display("FAIL %s cyc%0d imem_req got %b exp %b", name, k, imem_req, e_st == 0); end
            checks++; if (dmem_req !== (e_st == 3)) begin errors++; $display("FAIL %s cyc%0d dmem_req got %b exp %b", name, k, dmem_req, e_st == 3); end
            checks++; if (dmem_we !== (e_st == 3 && mw)) begin errors++; $display("FAIL %s cyc%0d dmem_we got %b exp %b", name, k, dmem_we, e_st == 3 && mw); end
            checks++; if (reg_we !== (e_st == 4)) begin errors++; $display("FAIL %s cyc%0d reg_we got %b exp %b", name, k, reg_we, e_st == 4); end
            checks++; if (retire !== (!bad && k == last)) begin errors++; $display("FAIL %s cyc%0d retire got %b exp %b", name, k, retire, !bad && k == last); end
            checks++; if (pc !== model_pc || imem_addr !== model_pc) begin errors++; $display("FAIL %s cyc%0d pc got %h/%h exp %h", name, k, pc, imem_addr, model_pc); end
            checks++; if (fault !== (e_st == 5)) begin errors++; $display("FAIL %s cyc%0d fault got %b exp %b", name, k, fault, e_st == 5); end
            checks++; if (wb_sel !== mtr) begin errors++; $display("FAIL %s cyc%0d wb_sel got %b exp %b", name, k, wb_sel, mtr); end
            if (e_st >= 1 && e_st <= 4) begin
                checks++; if (instr !== word) begin errors++; $display("FAIL %s cyc%0d instr got %h exp %h", name, k, instr, word); end
            end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        if (!bad) model_pc = npc;
        #1;
        if (!bad) begin
            checks++; if (pc !== model_pc || state !== 3'd0) begin errors++; $display("FAIL %s after pc got %h exp %h state got %0d exp 0", name, pc, model_pc, state); end
        end
        faulted = bad;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset state got %0d exp 0", state); end
        checks++; if (pc !== '0 || imem_addr !== '0) begin errors++; $display("FAIL reset pc got %h exp 0", pc); end
        checks++; if (instr !== 32'h0000_0013) begin errors++; $display("FAIL reset instr got %h exp 00000013", instr); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset fault got %b exp 0", fault); end
        checks++; if (imem_req !== 1'b1 || dmem_req !== 1'b0 || reg_we !== 1'b0 || retire !== 1'b0 || dmem_we !== 1'b0) begin
            errors++; $display("FAIL reset outputs got ireq=%b dreq=%b rwe=%b ret=%b dwe=%b exp 1 0 0 0 0", imem_req, dmem_req, reg_we, retire, dmem_we);
        end
        rst_n    = 1'b1;
        model_pc = '0;
    endtask

    task automatic test_add();
        bit f;
        do_reset();
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, 0, 0, "add", f);
        checks++; if (pc !== 10'h004) begin errors++; $display("FAIL add_pc got %h exp 004", pc); end
    endtask

    task automatic test_load();
        bit f;
        do_reset();
        run_instr(1, 0, 1, 1, 0, 0, 0, '0, 0, 3, "lw", f);
        checks++; if (pc !== 10'h004) begin errors++; $display("FAIL lw_pc got %h exp 004", pc); end
    endtask

    task automatic test_store();
        bit f;
        do_reset();
        run_instr(0, 1, 0, 0, 0, 0, 0, '0, 1, 2, "sw", f);
        checks++; if (pc !== 10'h004) begin errors++; $display("FAIL sw_pc got %h exp 004", pc); end
    endtask

    task automatic to_pc8();
        bit f;
        do_reset();
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, 0, 0, "pre0", f);
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, 1, 0, "pre1", f);
    endtask

    task automatic test_branch();
        bit f;
        to_pc8();
        run_instr(0, 0, 0, 0, 1, 0, 1, 10'h040, 0, 0, "beq_taken", f);
        checks++; if (pc !== 10'h040) begin errors++; $display("FAIL beq_taken_pc got %h exp 040", pc); end
        to_pc8();
        run_instr(0, 0, 0, 0, 1, 0, 0, 10'h040, 0, 0, "beq_not", f);
        checks++; if (pc !== 10'h00c) begin errors++; $display("FAIL beq_not_pc got %h exp 00c", pc); end
    endtask

    task automatic test_jal_misaligned();
        bit f;
        to_pc8();
        run_instr(0, 0, 0, 1, 0, 1, 0, 10'h3fe, 0, 0, "jal_mis", f);
        checks++; if (!f || fault !== 1'b1 || pc !== 10'h008) begin
            errors++; $display("FAIL jal_mis fault got %b pc got %h exp fault 1 pc 008", fault, pc);
        end
    endtask

    task automatic test_timeout();
        bit f;
        do_reset();
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, MT, 0, "fetch_to", f);
        do_reset();
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, MT - 1, 0, "fetch_edge", f);
        do_reset();
        run_instr(1, 0, 1, 1, 0, 0, 0, '0, 0, MT, "mem_to", f);
        do_reset();
        run_instr(0, 1, 0, 0, 0, 0, 0, '0, 0, MT - 1, "mem_edge", f);
    endtask

    task automatic test_wrap();
        bit f;
        do_reset();
        run_instr(0, 0, 0, 1, 0, 1, 0, 10'h3fc, 0, 0, "jal_3fc", f);
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, 0, 0, "wrap", f);
        checks++; if (pc !== 10'h000) begin errors++; $display("FAIL wrap_pc got %h exp 000", pc); end
    endtask

    task automatic test_reset_mid_mem();
        bit f;
        do_reset();
        run_instr(0, 0, 0, 1, 0, 0, 0, '0, 0, 0, "pre_rst", f);
        dec_mem_read = 1; dec_mem_write = 0; dec_mem_to_reg = 1; dec_reg_write = 1;
        dec_branch = 0; dec_jump = 0; branch_taken = 0;
        imem_rdata = $urandom;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd3 || dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mem entry state got %0d dreq %b exp 3 1", state, dmem_req); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (dmem_req !== 1'b0 || state !== 3'd0 || pc !== '0 || fault !== 1'b0) begin
            errors++; $display("FAIL rst_mem after dreq=%b state=%0d pc=%h fault=%b exp 0 0 000 0", dmem_req, state, pc, fault);
        end
        rst_n    = 1'b1;
        model_pc = '0;
        dmem_ack = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (state !== 3'd0 || imem_req !== 1'b1) begin errors++; $display("FAIL late_ack state got %0d ireq %b exp 0 1", state, imem_req); end
        dmem_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit            f;
        bit            mr, mw, mtr, rw, br, jp, bt;
        logic [AW-1:0] tgt;
        int            iw, dw, kind;
        do_reset();
        for (int n = 0; n < 80; n++) begin
            {mr, mw, mtr, rw, br, jp, bt} = '0;
            kind = $urandom_range(0, 6);
            tgt  = AW'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 9) == 0) tgt = tgt | AW'(2);
            case (kind)
                0: rw = 1;
                1: begin mr = 1; mtr = 1; rw = 1; end
                2: mw = 1;
                3: begin br = 1; bt = 1'($urandom_range(0, 1)); end
                4: begin jp = 1; rw = 1; end
                5: ;
                default: begin
                    if ($urandom_range(0, 3) == 0) begin mr = 1; mw = 1; end
                    else rw = 1;
                end
            endcase
            iw = $urandom_range(0, 4);
            dw = $urandom_range(0, 4);
            if ($urandom_range(0, 24) == 0) iw = $urandom_range(MT - 1, MT);
            if ($urandom_range(0, 24) == 0) dw = $urandom_range(MT - 1, MT);
            run_instr(mr, mw, mtr, rw, br, jp, bt, tgt, iw, dw, "rand", f);
            if (f) do_reset();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0;
        dec_mem_read = 0; dec_mem_write = 0; dec_mem_to_reg = 0;
        dec_reg_write = 0; dec_branch = 0; dec_jump = 0;
        branch_taken = 0; target_addr = '0;
        model_pc = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_load();
        test_store();
        test_branch();
        test_jal_misaligned();
        test_timeout();
        test_wrap();
        test_reset_mid_mem();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
